compare_weight_ctrl: RTL and testbench
======================================

# compare_weight_ctrl

Sequencer for the masked 10-bit weight-equality datapath `compare_weight`, which it instantiates.
- Accepts one pair of masked operands per transaction over a valid/ready handshake and holds them stable for the full datapath latency.
- Streams fresh PINI randomness from the PRNG into the datapath every cycle, restarting the evaluation if randomness starves.
- Returns the masked "differ" bit over a valid/ready handshake.
- Sits between the decapsulation weight-check logic and the shared PRNG.

## Interface
Parameters:
- `d`, 2, number of shares.
- `LATENCY`, 10, register stages from stable datapath inputs to a valid `compare_weight` output.
- `word`, 10 (localparam), operand width.
- `and_pini_nrnd`, d*(d-1)/2 (localparam), random bits per masked OR gate.

Ports:
- `clk`  in  1  clock; all logic rising-edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  controller can accept an operand pair.
- `a_input`  in  d*word  masked operand A, share-major.
- `b_input`  in  d*word  masked operand B, share-major.
- `rnd_in`  in  and_pini_nrnd*word  fresh randomness from the PRNG.
- `rnd_valid`  in  1  `rnd_in` is fresh this cycle.
- `rnd_ready`  out  1  controller consumes `rnd_in` this cycle.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_diff`  out  d  masked result; the XOR of the shares is 1 iff A != B.
- `busy`  out  1  high in any state other than IDLE.

## Operation
FSM states: IDLE, RUN, WAIT_RND, DONE. A counter `cnt` runs 0..LATENCY.

Transitions and actions:
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: capture `a_input`/`b_input` into `a_q`/`b_q`, set `cnt`=0, go to RUN.
- RUN:
  - `rnd_ready`=1; datapath rnd = `rnd_in`.
  - If `rnd_valid`=1 and `cnt`<LATENCY: `cnt`++.
  - If `rnd_valid`=1 and `cnt`==LATENCY: load `res_q` from the datapath output, go to DONE.
  - If `rnd_valid`=0: go to WAIT_RND, `cnt`=0. The evaluation is aborted; the datapath rnd is forced to all-zero that cycle.
- WAIT_RND:
  - `rnd_ready`=0; datapath rnd all-zero.
  - On `rnd_valid`=1: go to RUN, `cnt`=0. The full evaluation restarts on the held `a_q`/`b_q`.
- DONE:
  - `out_valid`=1, `out_diff`=`res_q`.
  - On `out_ready`: go to IDLE.

Datapath and data-handling rules:
- The datapath is always driven from `a_q`/`b_q`, never directly from the ports.
- `a_q`/`b_q` change only on an IDLE accept.
- Share-wise processing only. Shares are never combined, and `res_q` is stored per share.

Reset:
- Any cycle with `rst_n`=0 forces IDLE and `cnt`=0, including mid-RUN and DONE.
- Reset clears `res_q`, `a_q` and `b_q` to 0.
- Output values in reset and in the cycle after: `in_ready`=1 after reset; `out_valid`=0, `rnd_ready`=0, `busy`=0, `out_diff`=0.

## Timing
- Accept edge E0. RUN occupies the LATENCY+1 cycles after E0.
- With no starvation, `out_valid` rises in cycle E0+LATENCY+2 (12 cycles for the default).
- Exactly LATENCY+1 randomness words are consumed per successful evaluation.
- Each abort adds the WAIT_RND cycles plus a fresh LATENCY+1 RUN cycles.
- `in_ready` is combinational from state only. `in_ready` and `out_valid` are never high together.
- Output handshake:
  - `out_valid` stays high and `out_diff` stays stable until `out_ready`.
  - The accept edge returns the controller to IDLE.
  - The next operand can be accepted at the earliest one cycle after the result handshake (no same-cycle turnaround).
- Throughput: one comparison per LATENCY+3 cycles minimum.

## Configuration
`CMP_CTRL_ZEROIZE_EN`:
- Defined: on the DONE→IDLE handshake edge, `a_q`, `b_q` and `res_q` are cleared to 0 so no share residue persists. In IDLE the datapath inputs are therefore all-zero.
- Undefined: the registers retain their last values until the next accept or reset.
- Handshake timing is identical in both builds.

## Test plan
- d=2, A=0x155 (shares 0x0AA/0x1FF), B=A with different masks, `rnd_valid` held 1 → `out_valid` in cycle E0+12, XOR of `out_diff` shares = 0, 11 `rnd_ready` cycles.
- A=0x155, B=0x154, `rnd_valid`=1 → XOR of `out_diff` shares = 1 at E0+12.
- Same as the previous case but `rnd_valid`=0 at E0+5 for 3 cycles → WAIT_RND entered, RUN restarts with `cnt`=0, result still 1, `out_valid` at E0+5+3+11+1.
- Result ready with `out_ready` low for 7 cycles → `out_valid` and `out_diff` stable, `in_ready`=0 throughout, IDLE after the handshake.
- `rst_n`=0 at E0+6 mid-RUN → next cycle: IDLE, `out_valid`=0, `rnd_ready`=0, `busy`=0, `in_ready`=1; a new accept yields the correct result.
- With `CMP_CTRL_ZEROIZE_EN`: after the result handshake, internal `a_q`/`b_q`/`res_q` read 0. Without it they hold the previous values.

Source files
------------

// File: rtl/compare_weight_ctrl.sv
// Masked 10-bit weight-equality datapath (compare_weight) and its handshake sequencer (compare_weight_ctrl).
// Build macro CMP_CTRL_ZEROIZE_EN: clear a_q/b_q/res_q on every result handshake.

module compare_weight #(
  parameter int d       = 2,
  parameter int LATENCY = 10
) (
  input  logic                          clk,
  input  logic [d*10-1:0]               a,
  input  logic [(d*(d-1)/2)*10-1:0]     rnd,
  input  logic [d*10-1:0]               b,
  output logic [d-1:0]                  diff
);
  localparam int word = 10;
  localparam int nrnd = d * (d - 1) / 2;

  logic [word-1:0] x_d [d];
  logic [word-1:0] x_q [d];
  logic [d-1:0]    acc [word];
  logic [d-1:0]    term_q [1:word-1][d];
  logic            rf;

  function automatic int pair_idx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * d - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  // The last randomness slot refreshes bit 0 of the share-wise XOR so every rnd bit is consumed.
  assign rf = ^rnd[(word-1)*nrnd +: nrnd];

  always_comb begin
    for (int i = 0; i < d; i++) x_d[i] = a[i*word +: word] ^ b[i*word +: word];
    x_d[0][0]   = x_d[0][0] ^ rf;
    x_d[d-1][0] = x_d[d-1][0] ^ rf;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < d; i++) x_q[i] <= x_d[i];
  end

  // Serial OR chain: OR(x,y) = NOT(AND(NOT x, NOT y)), inversion applied to share 0 only.
  always_ff @(posedge clk) begin
    for (int k = 1; k < word; k++)
      for (int i = 0; i < d; i++)
        for (int j = 0; j < d; j++)
          if (i == j)
            term_q[k][i][j] <= (acc[k-1][i] ^ (i == 0)) & (x_q[j][k] ^ (j == 0));
          else
            term_q[k][i][j] <= ((acc[k-1][i] ^ (i == 0)) & (x_q[j][k] ^ (j == 0)))
                               ^ rnd[(k-1)*nrnd + pair_idx(i, j)];
  end

  always_comb begin
    for (int k = 0; k < word; k++) acc[k] = '0;
    for (int i = 0; i < d; i++) acc[0][i] = x_q[i][0];
    for (int k = 1; k < word; k++) begin
      for (int i = 0; i < d; i++) acc[k][i] = ^term_q[k][i];
      acc[k][0] = ~acc[k][0];
    end
  end

  if (LATENCY > word) begin : g_dly
    logic [d-1:0] dly_q [LATENCY-word];
    always_ff @(posedge clk) begin
      dly_q[0] <= acc[word-1];
      for (int s = 1; s < LATENCY - word; s++) dly_q[s] <= dly_q[s-1];
    end
    assign diff = dly_q[LATENCY-word-1];
  end else begin : g_nodly
    assign diff = acc[word-1];
  end
endmodule

module compare_weight_ctrl #(
  parameter int d       = 2,
  parameter int LATENCY = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [d*10-1:0]               a_input,
  input  logic [d*10-1:0]               b_input,
  input  logic [(d*(d-1)/2)*10-1:0]     rnd_in,
  input  logic                          rnd_valid,
  output logic                          rnd_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [d-1:0]                  out_diff,
  output logic                          busy
);
  localparam int word          = 10;
  localparam int and_pini_nrnd = d * (d - 1) / 2;
  localparam int CW            = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LATENCY);

  typedef enum logic [1:0] {IDLE, RUN, WAIT_RND, DONE} state_t;

  state_t                        state, state_next;
  logic [CW-1:0]                 cnt, cnt_next;
  logic [d*word-1:0]             a_q, b_q;
  logic [d-1:0]                  res_q, dp_diff;
  logic [and_pini_nrnd*word-1:0] dp_rnd;
  logic                          load_ops, load_res;
`ifdef CMP_CTRL_ZEROIZE_EN
  logic                          clear_regs;
`endif

  // A starved RUN cycle aborts the evaluation and feeds zero randomness that cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_ops   = 1'b0;
    load_res   = 1'b0;
    in_ready   = 1'b0;
    rnd_ready  = 1'b0;
    out_valid  = 1'b0;
    dp_rnd     = '0;
`ifdef CMP_CTRL_ZEROIZE_EN
    clear_regs = 1'b0;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_ops   = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        rnd_ready = 1'b1;
        if (!rnd_valid) begin
          cnt_next   = '0;
          state_next = WAIT_RND;
        end else begin
          dp_rnd = rnd_in;
          if (cnt == CNT_MAX) begin
            load_res   = 1'b1;
            state_next = DONE;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      WAIT_RND: begin
        if (rnd_valid) begin
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
`ifdef CMP_CTRL_ZEROIZE_EN
          clear_regs = 1'b1;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_ops) begin
        a_q <= a_input;
        b_q <= b_input;
      end
      if (load_res) res_q <= dp_diff;
`ifdef CMP_CTRL_ZEROIZE_EN
      if (clear_regs) begin
        a_q   <= '0;
        b_q   <= '0;
        res_q <= '0;
      end
`endif
    end
  end

  assign busy     = (state != IDLE);
  assign out_diff = out_valid ? res_q : '0;

  compare_weight #(.d(d), .LATENCY(LATENCY)) u_dp (
    .clk  (clk),
    .a    (a_q),
    .rnd  (dp_rnd),
    .b    (b_q),
    .diff (dp_diff)
  );
endmodule

// File: tb/tb_compare_weight_ctrl.sv
// Scoreboard bench for compare_weight_ctrl: directed operand pairs, a negedge monitor checks each result.
// Zeroize expectations follow CMP_CTRL_ZEROIZE_EN.

module tb_compare_weight_ctrl;
  localparam int D   = 2;
  localparam int LAT = 10;
  localparam int W   = 10;
  localparam int NR  = D * (D - 1) / 2;
  localparam int RW  = NR * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [D*W-1:0] a_input = '0;
  logic [D*W-1:0] b_input = '0;
  logic [RW-1:0] rnd_in = '0;
  logic          rnd_valid = 1'b1;
  logic          rnd_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [D-1:0]  out_diff;
  logic          busy;

  compare_weight_ctrl #(.d(D), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_input   (a_input),
    .b_input   (b_input),
    .rnd_in    (rnd_in),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  always @(posedge clk) begin
    #1;
    rnd_in = RW'($urandom);
  end

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  typedef struct {
    logic diff;
    int   lat;
    int   nrnd;
  } exp_t;
  exp_t exp_q[$];

  int acc_cyc = 0;
  int first_cyc = 0;
  int rnd_cnt = 0;
  bit seen = 1'b0;

  // Monitor: latency is measured from the accept cycle to the first out_valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen    = 1'b0;
      rnd_cnt = 0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cyc = cyc;
        rnd_cnt = 0;
      end
      if (rnd_valid && rnd_ready) rnd_cnt++;
      if (out_valid && !seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        seen = 1'b0;
        checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("diff_xor", 32'(^out_diff), 32'(e.diff));
          checkOutput("latency", 32'(first_cyc - acc_cyc), 32'(e.lat));
          checkOutput("rnd_words", 32'(rnd_cnt), 32'(e.nrnd));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a_val, input logic [W-1:0] a_msk,
                               input logic [W-1:0] b_val, input logic [W-1:0] b_msk,
                               input logic exp_diff, input int starve_at, input int starve_len,
                               input int hold_cycles, input int exp_lat, input int exp_nrnd);
    int k;
    logic [D-1:0] held;
    logic [D*W-1:0] a_pk;
    logic [D*W-1:0] b_pk;
    a_pk = {a_val ^ a_msk, a_msk};
    b_pk = {b_val ^ b_msk, b_msk};
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    a_input  = a_pk;
    b_input  = b_pk;
    in_valid = 1'b1;
    exp_q.push_back('{exp_diff, exp_lat, exp_nrnd});
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_input  = ~a_pk;
    b_input  = ~b_pk;
    k = 1;
    while (!out_valid && k < 100) begin
      rnd_valid = !(k >= starve_at && k < starve_at + starve_len);
      if (starve_len > 0 && k == starve_at + 1) checkOutput("wait_rnd_no_ready", 32'(rnd_ready), 32'd0);
      if (starve_len > 0 && k == starve_at + starve_len + 1) checkOutput("cnt_restart", 32'(dut.cnt), 32'd0);
      @(posedge clk); #1;
      k++;
    end
    rnd_valid = 1'b1;
    checkOutput("out_valid_timeout", 32'(out_valid), 32'd1);
    held = out_diff;
    for (int h = 0; h < hold_cycles; h++) begin
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_diff_stable", 32'(out_diff), 32'(held));
      checkOutput("hold_no_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_not_busy", 32'(busy), 32'd0);
`ifdef CMP_CTRL_ZEROIZE_EN
    checkOutput("zeroize_a_q", 32'(dut.a_q), 32'd0);
    checkOutput("zeroize_b_q", 32'(dut.b_q), 32'd0);
    checkOutput("zeroize_res_q", 32'(dut.res_q), 32'd0);
`else
    checkOutput("retain_a_q", 32'(dut.a_q), 32'(a_pk));
    checkOutput("retain_b_q", 32'(dut.b_q), 32'(b_pk));
    checkOutput("retain_res_xor", 32'(^dut.res_q), 32'(exp_diff));
`endif
  endtask

  task automatic resetMidRun();
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    a_input  = {10'h155 ^ 10'h0AA, 10'h0AA};
    b_input  = {10'h154 ^ 10'h2A5, 10'h2A5};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_rnd_ready", 32'(rnd_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_diff", 32'(out_diff), 32'd0);
    checkOutput("rst_a_q", 32'(dut.a_q), 32'd0);
    checkOutput("rst_res_q", 32'(dut.res_q), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_rnd_ready", 32'(rnd_ready), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_diff", 32'(out_diff), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // equal operands, different masks
    applyStimulus(10'h155, 10'h0AA, 10'h155, 10'h3C3, 1'b0, 0, 0, 0, 12, 11);
    // differ in the LSB
    applyStimulus(10'h155, 10'h0AA, 10'h154, 10'h2A5, 1'b1, 0, 0, 0, 12, 11);
    // randomness starved for 3 cycles from cycle 5
    applyStimulus(10'h155, 10'h0AA, 10'h154, 10'h2A5, 1'b1, 5, 3, 0, 20, 15);
    // downstream back-pressure for 7 cycles
    applyStimulus(10'h3FF, 10'h155, 10'h3FF, 10'h0F0, 1'b0, 0, 0, 7, 12, 11);
    resetMidRun();
    applyStimulus(10'h200, 10'h1AB, 10'h000, 10'h3C0, 1'b1, 0, 0, 0, 12, 11);
    applyStimulus(10'h000, 10'h2D2, 10'h000, 10'h01F, 1'b0, 0, 0, 2, 12, 11);
    applyStimulus(10'h001, 10'h3FF, 10'h000, 10'h3FF, 1'b1, 0, 0, 0, 12, 11);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
